// File: rtl/ball_motion_controller.sv
// Per-ball fixed-point motion integrator: takes shots and collision velocities, integrates
// position once per frame with friction and edge clamping, and tracks the hole/respawn status.
module ball_motion_controller #(
  parameter int INITIAL_X       = 280,
  parameter int INITIAL_Y       = 185,
  parameter int FIXED_SHIFT     = 6,
  parameter int FRICTION_PERIOD = 4,
  parameter int MAX_X           = 607,
  parameter int MAX_Y           = 447
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               shotValid,
  input  logic signed [10:0] shotVelX,
  input  logic signed [10:0] shotVelY,
  input  logic               collisionOccurred,
  input  logic signed [10:0] collVelX,
  input  logic signed [10:0] collVelY,
  input  logic               holeHit,
  input  logic [2:0]         holeNum,
  input  logic               respawn,
  output logic [10:0]        topLeftPosX,
  output logic [10:0]        topLeftPosY,
  output logic signed [10:0] velX,
  output logic signed [10:0] velY,
  output logic               ballMoving,
  output logic               ballInHole,
  output logic [2:0]         holeNumOut
);

  localparam int PW = 11 + FIXED_SHIFT;
  localparam int CW = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRICTION_PERIOD - 1);
  localparam logic signed [PW-1:0] INIT_POS_X = PW'(INITIAL_X << FIXED_SHIFT);
  localparam logic signed [PW-1:0] INIT_POS_Y = PW'(INITIAL_Y << FIXED_SHIFT);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MOVING  = 2'd1;
  localparam logic [1:0] ST_IN_HOLE = 2'd2;

  logic [1:0]               state_q, state_d;
  logic signed [PW-1:0]     pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [10:0]       vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  logic                     pend_valid_q, pend_valid_d;
  logic signed [10:0]       pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [2:0]               hole_num_q, hole_num_d;
  logic [10:0]              top_x_q, top_y_q;
  logic                     frame_update;
  logic signed [10:0]       vx_frame, vy_frame;

  // Integrate one axis and clamp the pixel part to [0, max_pix]; out-of-range clamps drop the fraction.
  function automatic logic signed [PW-1:0] advance(input logic signed [PW-1:0] pos,
                                                   input logic signed [10:0] vel,
                                                   input int max_pix);
    logic signed [PW:0] sum;
    sum = {pos[PW-1], pos} + {{(PW-10){vel[10]}}, vel};
    if (sum[PW])
      advance = '0;
    else if (int'(sum >>> FIXED_SHIFT) > max_pix)
      advance = PW'(max_pix << FIXED_SHIFT);
    else
      advance = sum[PW-1:0];
  endfunction

  function automatic logic signed [10:0] toward_zero(input logic signed [10:0] v);
    if (v > 0)      toward_zero = v - 11'sd1;
    else if (v < 0) toward_zero = v + 11'sd1;
    else            toward_zero = v;
  endfunction

  always_comb begin
    state_d      = state_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    vel_x_d      = vel_x_q;
    vel_y_d      = vel_y_q;
    pend_valid_d = pend_valid_q;
    pend_x_d     = pend_x_q;
    pend_y_d     = pend_y_q;
    cnt_d        = cnt_q;
    hole_num_d   = hole_num_q;
    frame_update = 1'b0;
    vx_frame     = vel_x_q;
    vy_frame     = vel_y_q;

    if (respawn) begin
      state_d      = ST_IDLE;
      pos_x_d      = INIT_POS_X;
      pos_y_d      = INIT_POS_Y;
      vel_x_d      = '0;
      vel_y_d      = '0;
      pend_valid_d = 1'b0;
      cnt_d        = '0;
    end else if (state_q != ST_IN_HOLE) begin
      if (holeHit) begin
        state_d      = ST_IN_HOLE;
        vel_x_d      = '0;
        vel_y_d      = '0;
        pend_valid_d = 1'b0;
        cnt_d        = '0;
        hole_num_d   = holeNum;
      end else begin
        frame_update = startOfFrame && ((state_q == ST_MOVING) || pend_valid_q);
        if (frame_update) begin
          if (pend_valid_q) begin
            vx_frame = pend_x_q;
            vy_frame = pend_y_q;
          end
          pend_valid_d = 1'b0;
          pos_x_d      = advance(pos_x_q, vx_frame, MAX_X);
          pos_y_d      = advance(pos_y_q, vy_frame, MAX_Y);
          // Friction is applied after the position step, using the pre-friction velocity.
          if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            vx_frame = toward_zero(vx_frame);
            vy_frame = toward_zero(vy_frame);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
          vel_x_d = vx_frame;
          vel_y_d = vy_frame;
          if ((vx_frame == 0) && (vy_frame == 0)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = ST_MOVING;
          end
        end else if ((state_q == ST_IDLE) && shotValid && ((shotVelX != 0) || (shotVelY != 0))) begin
          vel_x_d = shotVelX;
          vel_y_d = shotVelY;
          state_d = ST_MOVING;
        end
        // A collision on a frame-start cycle always opens the next frame's latch.
        if (collisionOccurred && (startOfFrame || !pend_valid_q)) begin
          pend_valid_d = 1'b1;
          pend_x_d     = collVelX;
          pend_y_d     = collVelY;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ST_IDLE;
      pos_x_q      <= INIT_POS_X;
      pos_y_q      <= INIT_POS_Y;
      vel_x_q      <= '0;
      vel_y_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      cnt_q        <= '0;
      hole_num_q   <= '0;
      top_x_q      <= 11'(INITIAL_X);
      top_y_q      <= 11'(INITIAL_Y);
    end else begin
      state_q      <= state_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      vel_x_q      <= vel_x_d;
      vel_y_q      <= vel_y_d;
      pend_valid_q <= pend_valid_d;
      pend_x_q     <= pend_x_d;
      pend_y_q     <= pend_y_d;
      cnt_q        <= cnt_d;
      hole_num_q   <= hole_num_d;
      top_x_q      <= pos_x_d[PW-1:FIXED_SHIFT];
      top_y_q      <= pos_y_d[PW-1:FIXED_SHIFT];
    end
  end

  assign topLeftPosX = top_x_q;
  assign topLeftPosY = top_y_q;
  assign velX        = vel_x_q;
  assign velY        = vel_y_q;
  assign ballMoving  = (state_q == ST_MOVING);
  assign ballInHole  = (state_q == ST_IN_HOLE);
  assign holeNumOut  = hole_num_q;

endmodule

// File: tb/tb_ball_motion_controller.sv
// Bench for ball_motion_controller: a directed vector table, hand-written corner sequences,
// and random traffic checked against a velocity-centred behavioural model.
module tb_ball_motion_controller;

  localparam int SCALE  = 64;
  localparam int PERIOD = 4;
  localparam int MAXX   = 607;
  localparam int MAXY   = 447;
  localparam int INITX  = 280;
  localparam int INITY  = 185;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               resetN;
  logic               startOfFrame, shotValid, collisionOccurred, holeHit, respawn;
  logic signed [10:0] shotVelX, shotVelY, collVelX, collVelY;
  logic [2:0]         holeNum;
  logic [10:0]        topLeftPosX, topLeftPosY;
  logic signed [10:0] velX, velY;
  logic               ballMoving, ballInHole;
  logic [2:0]         holeNumOut;

  ball_motion_controller dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .shotValid(shotValid), .shotVelX(shotVelX), .shotVelY(shotVelY),
    .collisionOccurred(collisionOccurred), .collVelX(collVelX), .collVelY(collVelY),
    .holeHit(holeHit), .holeNum(holeNum), .respawn(respawn),
    .topLeftPosX(topLeftPosX), .topLeftPosY(topLeftPosY),
    .velX(velX), .velY(velY), .ballMoving(ballMoving), .ballInHole(ballInHole),
    .holeNumOut(holeNumOut)
  );

  typedef struct {
    bit sof; bit shot; int svx; int svy;
    bit coll; int cvx; int cvy;
    bit hole; int hnum; bit resp;
  } stim_t;

  typedef struct {
    stim_t s;
    int ex; int ey; int evx; int evy; bit emov; bit ehole; int ehn;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: the ball is "moving" exactly when it is out of a hole with nonzero velocity.
  int m_px, m_py, m_vx, m_vy, m_pvx, m_pvy, m_frames, m_hn;
  bit m_pend, m_in_hole;

  function automatic stim_t mk(bit sof, bit shot, int svx, int svy, bit coll, int cvx, int cvy,
                               bit hole, int hnum, bit resp);
    stim_t s;
    s.sof = sof; s.shot = shot; s.svx = svx; s.svy = svy;
    s.coll = coll; s.cvx = cvx; s.cvy = cvy;
    s.hole = hole; s.hnum = hnum; s.resp = resp;
    return s;
  endfunction

  function automatic vec_t mkv(stim_t s, int ex, int ey, int evx, int evy, bit emov, bit ehole, int ehn);
    vec_t v;
    v.s = s; v.ex = ex; v.ey = ey; v.evx = evx; v.evy = evy;
    v.emov = emov; v.ehole = ehole; v.ehn = ehn;
    return v;
  endfunction

  function automatic int clampf(int p, int maxp);
    if (p < 0) return 0;
    if ((p / SCALE) > maxp) return maxp * SCALE;
    return p;
  endfunction

  function automatic int shrink(int v);
    if (v > 0) return v - 1;
    if (v < 0) return v + 1;
    return v;
  endfunction

  task automatic model_respawn();
    m_px = INITX * SCALE; m_py = INITY * SCALE;
    m_vx = 0; m_vy = 0; m_pend = 0; m_frames = 0; m_in_hole = 0;
  endtask

  task automatic model_reset();
    model_respawn();
    m_hn = 0; m_pvx = 0; m_pvy = 0;
  endtask

  task automatic model_step(input stim_t s);
    bit moving, had_pend, frame;
    if (s.resp) begin
      model_respawn();
      return;
    end
    if (m_in_hole) return;
    if (s.hole) begin
      m_in_hole = 1; m_vx = 0; m_vy = 0; m_pend = 0; m_frames = 0; m_hn = s.hnum;
      return;
    end
    moving   = (m_vx != 0) || (m_vy != 0);
    had_pend = m_pend;
    frame    = s.sof && (moving || had_pend);
    if (frame) begin
      if (had_pend) begin m_vx = m_pvx; m_vy = m_pvy; end
      m_pend = 0;
      m_px = clampf(m_px + m_vx, MAXX);
      m_py = clampf(m_py + m_vy, MAXY);
      m_frames++;
      if ((m_frames % PERIOD) == 0) begin m_vx = shrink(m_vx); m_vy = shrink(m_vy); end
      if ((m_vx == 0) && (m_vy == 0)) m_frames = 0;
    end else if (!moving && s.shot && ((s.svx != 0) || (s.svy != 0))) begin
      m_vx = s.svx; m_vy = s.svy;
    end
    if (s.coll && (s.sof || !had_pend)) begin
      m_pend = 1; m_pvx = s.cvx; m_pvy = s.cvy;
    end
  endtask

  task automatic apply(input stim_t s);
    startOfFrame = s.sof; shotValid = s.shot;
    shotVelX = 11'(s.svx); shotVelY = 11'(s.svy);
    collisionOccurred = s.coll; collVelX = 11'(s.cvx); collVelY = 11'(s.cvy);
    holeHit = s.hole; holeNum = 3'(s.hnum); respawn = s.resp;
  endtask

  // One clock of stimulus; the model advances on the same edge, inputs return to idle afterwards.
  task automatic drive(input stim_t s);
    @(negedge clk);
    apply(s);
    @(posedge clk);
    #1;
    model_step(s);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic check(input string name, input int ex, input int ey, input int evx, input int evy,
                       input bit emov, input bit ehole, input int ehn);
    checks++;
    if (topLeftPosX !== 11'(ex) || topLeftPosY !== 11'(ey) || velX !== 11'(evx) ||
        velY !== 11'(evy) || ballMoving !== emov || ballInHole !== ehole || holeNumOut !== 3'(ehn)) begin
      errors++;
      $display("FAIL %s: got pos=(%0d,%0d) vel=(%0d,%0d) mov=%0b hole=%0b hn=%0d, expected pos=(%0d,%0d) vel=(%0d,%0d) mov=%0b hole=%0b hn=%0d",
               name, topLeftPosX, topLeftPosY, velX, velY, ballMoving, ballInHole, holeNumOut,
               ex, ey, evx, evy, emov, ehole, ehn);
    end
  endtask

  task automatic check_model(input string name);
    check(name, m_px / SCALE, m_py / SCALE, m_vx, m_vy,
          !m_in_hole && ((m_vx != 0) || (m_vy != 0)), m_in_hole, m_hn);
  endtask

  vec_t vecs[17];
  stim_t sof_s, nop_s, rsp_s;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    sof_s = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop_s = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rsp_s = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    vecs[0]  = mkv(mk(0, 1, 64, 0, 0, 0, 0, 0, 0, 0),    280, 185, 64, 0, 1, 0, 0);
    vecs[1]  = mkv(sof_s,                                281, 185, 64, 0, 1, 0, 0);
    vecs[2]  = mkv(nop_s,                                281, 185, 64, 0, 1, 0, 0);
    vecs[3]  = mkv(sof_s,                                282, 185, 64, 0, 1, 0, 0);
    vecs[4]  = mkv(sof_s,                                283, 185, 64, 0, 1, 0, 0);
    vecs[5]  = mkv(sof_s,                                284, 185, 63, 0, 1, 0, 0);
    vecs[6]  = mkv(mk(0, 0, 0, 0, 1, -64, 0, 0, 0, 0),   284, 185, 63, 0, 1, 0, 0);
    vecs[7]  = mkv(mk(0, 0, 0, 0, 1, 100, 0, 0, 0, 0),   284, 185, 63, 0, 1, 0, 0);
    vecs[8]  = mkv(sof_s,                                283, 185, -64, 0, 1, 0, 0);
    vecs[9]  = mkv(sof_s,                                282, 185, -64, 0, 1, 0, 0);
    vecs[10] = mkv(mk(0, 0, 0, 0, 1, 7, 7, 1, 5, 0),     282, 185, 0, 0, 0, 1, 5);
    vecs[11] = mkv(mk(0, 1, 50, 50, 0, 0, 0, 0, 0, 0),   282, 185, 0, 0, 0, 1, 5);
    vecs[12] = mkv(mk(1, 0, 0, 0, 1, 30, 30, 0, 0, 0),   282, 185, 0, 0, 0, 1, 5);
    vecs[13] = mkv(rsp_s,                                280, 185, 0, 0, 0, 0, 5);
    vecs[14] = mkv(sof_s,                                280, 185, 0, 0, 0, 0, 5);
    vecs[15] = mkv(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0),     280, 185, 0, 0, 0, 0, 5);
    vecs[16] = mkv(mk(1, 1, -3, 2, 0, 0, 0, 0, 0, 0),    280, 185, -3, 2, 1, 0, 5);

    resetN = 1'b0;
    apply(nop_s);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", INITX, INITY, 0, 0, 0, 0, 0);
    @(negedge clk);
    resetN = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].s);
      check($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].evx, vecs[i].evy,
            vecs[i].emov, vecs[i].ehole, vecs[i].ehn);
      $display("vec %0d: pos=(%0d,%0d) vel=(%0d,%0d) mov=%0b hole=%0b hn=%0d",
               i, topLeftPosX, topLeftPosY, velX, velY, ballMoving, ballInHole, holeNumOut);
    end

    // Friction decay of a small shot down to rest.
    drive(rsp_s);
    drive(mk(0, 1, -3, 2, 0, 0, 0, 0, 0, 0));
    for (int f = 1; f <= 12; f++) begin
      drive(sof_s);
      check_model($sformatf("fric_f%0d", f));
      if (f == 4)  check("fric_f4_const", 279, 185, -2, 1, 1, 0, 5);
      if (f == 8)  check("fric_f8_const", 279, 185, -1, 0, 1, 0, 5);
      if (f == 12) check("fric_f12_const", 279, 185, 0, 0, 0, 0, 5);
      $display("friction frame %0d: pos=(%0d,%0d) vel=(%0d,%0d) mov=%0b",
               f, topLeftPosX, topLeftPosY, velX, velY, ballMoving);
    end

    // Right-edge clamp.
    drive(rsp_s);
    drive(mk(0, 1, 1000, 0, 0, 0, 0, 0, 0, 0));
    for (int f = 1; f <= 25; f++) begin
      drive(sof_s);
      check_model($sformatf("clamp_f%0d", f));
    end
    check("clamp_edge", 607, 185, 994, 0, 1, 0, 5);
    drive(mk(0, 0, 0, 0, 1, -64, 0, 0, 0, 0));
    drive(sof_s);
    check("clamp_606", 606, 185, -64, 0, 1, 0, 5);
    drive(mk(0, 0, 0, 0, 1, 128, 0, 0, 0, 0));
    drive(sof_s);
    check("clamp_607", 607, 185, 128, 0, 1, 0, 5);
    drive(sof_s);
    check("clamp_hold", 607, 185, 127, 0, 1, 0, 5);
    $display("clamp sequence: pos=(%0d,%0d) vel=(%0d,%0d)", topLeftPosX, topLeftPosY, velX, velY);

    // Asynchronous reset while moving.
    drive(rsp_s);
    drive(mk(0, 1, 200, 0, 0, 0, 0, 0, 0, 0));
    for (int f = 1; f <= 3; f++) begin
      drive(sof_s);
      check_model($sformatf("prereset_f%0d", f));
    end
    @(posedge clk);
    #3;
    resetN = 1'b0;
    #1;
    check("async_reset", INITX, INITY, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    resetN = 1'b1;
    drive(sof_s);
    check("post_reset_sof", INITX, INITY, 0, 0, 0, 0, 0);
    $display("async reset: pos=(%0d,%0d) vel=(%0d,%0d)", topLeftPosX, topLeftPosY, velX, velY);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      stim_t s;
      s = nop_s;
      s.sof  = ((c % 10) == 9) || ($urandom_range(0, 29) == 0);
      s.shot = ($urandom_range(0, 7) == 0);
      s.svx  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 600)) - 300;
      s.svy  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 600)) - 300;
      s.coll = ($urandom_range(0, 11) == 0);
      s.cvx  = int'($urandom_range(0, 2047)) - 1024;
      s.cvy  = int'($urandom_range(0, 2047)) - 1024;
      s.hole = ($urandom_range(0, 149) == 0);
      s.hnum = int'($urandom_range(0, 7));
      s.resp = m_in_hole ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 199) == 0);
      drive(s);
      check_model($sformatf("rand%0d", c));
      if (s.sof)
        $display("rand cycle %0d: pos=(%0d,%0d) vel=(%0d,%0d) mov=%0b hole=%0b hn=%0d",
                 c, topLeftPosX, topLeftPosY, velX, velY, ballMoving, ballInHole, holeNumOut);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
